// File: rtl/vga_text_ctrl.sv
// VGA text-mode controller: H/V timing, character-grid address walk and a
// 2-stage glyph-to-RGB pipeline with fg/bg colour and a blinking cursor.
module vga_text_ctrl #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int CHAR_W       = 9,
    parameter int CHAR_H       = 16,
    parameter bit HS_POL       = 1'b0,
    parameter bit VS_POL       = 1'b0,
    parameter int BLINK_FRAMES = 30,
    parameter int CX_W         = 7,
    parameter int CY_W         = 5
) (
    input  logic            pclk,
    input  logic            reset,
    input  logic            rom_data,
    input  logic [23:0]     fg_color,
    input  logic [23:0]     bg_color,
    input  logic            cursor_en,
    input  logic [CX_W-1:0] cursor_x,
    input  logic [CY_W-1:0] cursor_y,
    output logic [CX_W-1:0] char_x,
    output logic [CY_W-1:0] char_y,
    output logic [3:0]      cell_x,
    output logic [3:0]      cell_y,
    output logic            hsync,
    output logic            vsync,
    output logic            valid,
    output logic            frame_start,
    output logic [7:0]      vga_r,
    output logic [7:0]      vga_g,
    output logic [7:0]      vga_b
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SYN_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYN_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYN_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYN_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]    CELL_X_MAX = 4'(CHAR_W - 1);
    localparam logic [3:0]    CELL_Y_MAX = 4'(CHAR_H - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    // Stage 0: raster and cell counters
    logic [HW-1:0]   h_cnt_q, h_cnt_d;
    logic [VW-1:0]   v_cnt_q, v_cnt_d;
    logic [3:0]      cell_x_q, cell_x_d, cell_y_q, cell_y_d;
    logic [CX_W-1:0] char_x_q, char_x_d;
    logic [CY_W-1:0] char_y_q, char_y_d;
    logic [BW-1:0]   frame_cnt_q, frame_cnt_d;
    logic            blink_on_q, blink_on_d;
    logic            line_end, frame_end, active0, hs0, vs0, fs0;

    // Stage 1: delayed timing and character position
    logic            s1_active_q, s1_active_d;
    logic            s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_fs_q, s1_fs_d;
    logic [CX_W-1:0] s1_char_x_q, s1_char_x_d;
    logic [CY_W-1:0] s1_char_y_q, s1_char_y_d;
    logic            cursor_hit, pixel;

    // Stage 2: registered outputs
    logic [23:0]     rgb_q, rgb_d;
    logic            hsync_q, hsync_d, vsync_q, vsync_d;
    logic            valid_q, valid_d, fs_q, fs_d;

    always_comb begin
        line_end  = (h_cnt_q == H_LAST);
        frame_end = line_end && (v_cnt_q == V_LAST);
        active0   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs0       = ((h_cnt_q >= H_SYN_BEG) && (h_cnt_q < H_SYN_END)) ? HS_POL : ~HS_POL;
        vs0       = ((v_cnt_q >= V_SYN_BEG) && (v_cnt_q < V_SYN_END)) ? VS_POL : ~VS_POL;
        fs0       = (h_cnt_q == '0) && (v_cnt_q == '0);

        h_cnt_d = line_end ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (line_end) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;

        // A truncated last cell needs no special case: the line end clears it.
        cell_x_d = cell_x_q;
        char_x_d = char_x_q;
        if (active0) begin
            if (h_cnt_q == H_ACT_LAST) begin
                cell_x_d = '0;
                char_x_d = '0;
            end else if (cell_x_q == CELL_X_MAX) begin
                cell_x_d = '0;
                char_x_d = char_x_q + 1'b1;
            end else begin
                cell_x_d = cell_x_q + 1'b1;
            end
        end

        cell_y_d = cell_y_q;
        char_y_d = char_y_q;
        if (frame_end) begin
            cell_y_d = '0;
            char_y_d = '0;
        end else if (line_end && (v_cnt_q < V_ACT)) begin
            if (cell_y_q == CELL_Y_MAX) begin
                cell_y_d = '0;
                char_y_d = char_y_q + 1'b1;
            end else begin
                cell_y_d = cell_y_q + 1'b1;
            end
        end

        frame_cnt_d = frame_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_end) begin
            if (frame_cnt_q == BLINK_LAST) begin
                frame_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        char_x = active0 ? char_x_q : '0;
        char_y = active0 ? char_y_q : '0;
        cell_x = active0 ? cell_x_q : '0;
        cell_y = active0 ? cell_y_q : '0;

        s1_active_d = active0;
        s1_hs_d     = hs0;
        s1_vs_d     = vs0;
        s1_fs_d     = fs0;
        s1_char_x_d = char_x;
        s1_char_y_d = char_y;

        // rom_data belongs to the address registered into stage 1.
        cursor_hit = cursor_en && blink_on_q &&
                     (s1_char_x_q == cursor_x) && (s1_char_y_q == cursor_y);
        pixel      = rom_data ^ cursor_hit;
        rgb_d      = s1_active_q ? (pixel ? fg_color : bg_color) : '0;
        hsync_d    = s1_hs_q;
        vsync_d    = s1_vs_q;
        valid_d    = s1_active_q;
        fs_d       = s1_fs_q;

        hsync       = hsync_q;
        vsync       = vsync_q;
        valid       = valid_q;
        frame_start = fs_q;
        vga_r       = rgb_q[23:16];
        vga_g       = rgb_q[15:8];
        vga_b       = rgb_q[7:0];
    end

    // NOTE: state updates use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse pipeline stages.
    always_ff @(posedge pclk) begin
        if (!reset) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            cell_x_q    <= '0;
            cell_y_q    <= '0;
            char_x_q    <= '0;
            char_y_q    <= '0;
            frame_cnt_q <= '0;
            blink_on_q  <= 1'b0;
            // NOTE: the pipeline stages are reset too, so a mid-frame reset
            // shows blanking with idle syncs instead of stale pixels.
            s1_active_q <= 1'b0;
            s1_hs_q     <= ~HS_POL;
            s1_vs_q     <= ~VS_POL;
            s1_fs_q     <= 1'b0;
            s1_char_x_q <= '0;
            s1_char_y_q <= '0;
            rgb_q       <= '0;
            hsync_q     <= ~HS_POL;
            vsync_q     <= ~VS_POL;
            valid_q     <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            cell_x_q    <= cell_x_d;
            cell_y_q    <= cell_y_d;
            char_x_q    <= char_x_d;
            char_y_q    <= char_y_d;
            frame_cnt_q <= frame_cnt_d;
            blink_on_q  <= blink_on_d;
            s1_active_q <= s1_active_d;
            s1_hs_q     <= s1_hs_d;
            s1_vs_q     <= s1_vs_d;
            s1_fs_q     <= s1_fs_d;
            s1_char_x_q <= s1_char_x_d;
            s1_char_y_q <= s1_char_y_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            valid_q     <= valid_d;
            fs_q        <= fs_d;
        end
    end
endmodule

// File: tb/tb_vga_text_ctrl.sv
// Testbench for vga_text_ctrl on a scaled-down raster: random inputs compared
// each cycle against an arithmetic model of the raster, cell grid and blink.
module tb_vga_text_ctrl;
    localparam int HA = 40, HFP = 4, HSW = 6, HBP = 5;
    localparam int VA = 36, VFP = 2, VSW = 2, VBP = 3;
    localparam int CW = 9, CH = 8, BF = 2, CXW = 3, CYW = 3;
    localparam bit HPOL = 1'b0, VPOL = 1'b1;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;

    logic           pclk = 1'b0;
    logic           reset;
    logic           rom_data;
    logic [23:0]    fg_color, bg_color;
    logic           cursor_en;
    logic [CXW-1:0] cursor_x;
    logic [CYW-1:0] cursor_y;
    logic [CXW-1:0] char_x;
    logic [CYW-1:0] char_y;
    logic [3:0]     cell_x, cell_y;
    logic           hsync, vsync, valid, frame_start;
    logic [7:0]     vga_r, vga_g, vga_b;

    vga_text_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .CHAR_W(CW), .CHAR_H(CH), .HS_POL(HPOL), .VS_POL(VPOL),
        .BLINK_FRAMES(BF), .CX_W(CXW), .CY_W(CYW)
    ) dut (
        .pclk(pclk), .reset(reset), .rom_data(rom_data),
        .fg_color(fg_color), .bg_color(bg_color),
        .cursor_en(cursor_en), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .char_x(char_x), .char_y(char_y), .cell_x(cell_x), .cell_y(cell_y),
        .hsync(hsync), .vsync(vsync), .valid(valid), .frame_start(frame_start),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        bit active;
        int cx, cy, px, py;
        bit hs, vs, fs;
    } s0_t;

    int checks = 0;
    int errors = 0;
    // t0/t1/t2: cycles since reset for the current and two previous cycles
    int t0 = 0, t1 = 0, t2 = 0;
    bit r0 = 1'b1, r1 = 1'b1;
    logic cur_rst_n = 1'b0;

    function automatic s0_t stage0(input int t);
        s0_t s;
        int h, v;
        h = t % HT;
        v = (t / HT) % VT;
        s.active = (h < HA) && (v < VA);
        s.cx = s.active ? h / CW : 0;
        s.px = s.active ? h % CW : 0;
        s.cy = s.active ? v / CH : 0;
        s.py = s.active ? v % CH : 0;
        s.hs = (h >= HA + HFP && h < HA + HFP + HSW) ? HPOL : !HPOL;
        s.vs = (v >= VA + VFP && v < VA + VFP + VSW) ? VPOL : !VPOL;
        s.fs = (h == 0) && (v == 0);
        return s;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed %h expected %h", tag, t0, obs, exp);
        end
    endtask

    // One clock: update the model at the edge, drive inputs for this cycle
    // (reset value applies to the next edge), then check on the falling edge.
    task automatic step(input logic rst_n_next, input int mode);
        s0_t e0, e2;
        logic p_rom, p_en;
        logic [23:0] p_fg, p_bg, exp_rgb;
        logic [CXW-1:0] p_cx;
        logic [CYW-1:0] p_cy;
        bit blink, hit;
        logic [3:0] exp_ctl;
        @(posedge pclk);
        r1 = r0;
        r0 = !cur_rst_n;
        t2 = t1;
        t1 = t0;
        t0 = r0 ? 0 : t1 + 1;
        p_rom = rom_data; p_en = cursor_en; p_fg = fg_color; p_bg = bg_color;
        p_cx = cursor_x; p_cy = cursor_y;
        #1;
        reset = rst_n_next;
        cur_rst_n = rst_n_next;
        rom_data = 1'($urandom);
        if (mode == 0) begin
            fg_color  = 24'($urandom);
            bg_color  = 24'($urandom);
            cursor_en = 1'($urandom);
            cursor_x  = CXW'($urandom_range(0, 4));
            cursor_y  = CYW'($urandom_range(0, 4));
        end else begin
            fg_color  = 24'hFFFFFF;
            bg_color  = 24'h0000CE;
            cursor_en = 1'b1;
            cursor_x  = CXW'(3);
            cursor_y  = CYW'(1);
        end
        @(negedge pclk);
        e0 = stage0(t0);
        check("addr", 64'({char_x, char_y, cell_x, cell_y}),
              64'({CXW'(e0.cx), CYW'(e0.cy), 4'(e0.px), 4'(e0.py)}));
        if (r0 || r1) begin
            exp_ctl = {!HPOL, !VPOL, 1'b0, 1'b0};
            exp_rgb = 24'h0;
        end else begin
            e2 = stage0(t2);
            blink = (((t1 / FRAME) / BF) % 2) == 1;
            hit = p_en && blink && (e2.cx == int'(p_cx)) && (e2.cy == int'(p_cy));
            exp_rgb = e2.active ? ((p_rom ^ hit) ? p_fg : p_bg) : 24'h0;
            exp_ctl = {e2.hs, e2.vs, e2.active, e2.fs};
        end
        check("sync_valid_fs", 64'({hsync, vsync, valid, frame_start}), 64'(exp_ctl));
        check("rgb", 64'({vga_r, vga_g, vga_b}), 64'(exp_rgb));
    endtask

    initial begin
        reset = 1'b0; rom_data = 1'b0; fg_color = '0; bg_color = '0;
        cursor_en = 1'b0; cursor_x = '0; cursor_y = '0;

        for (int i = 0; i < 5; i++) step(1'b0, 0);
        step(1'b1, 0);

        for (int i = 0; i < 2 * FRAME && errors < 50; i++) step(1'b1, 0);

        // Single-cycle reset while line 20 pixel 30 is on the address bus.
        for (int i = 0; i < FRAME && (t0 % FRAME) != 20 * HT + 29 && errors < 50; i++)
            step(1'b1, 0);
        step(1'b0, 0);
        step(1'b1, 1);

        for (int i = 0; i < 8 * FRAME && errors < 50; i++) step(1'b1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
